// File: rtl/rca_seq_adder_pkg.sv
// Shared types and sizing helpers for the time-multiplexed ripple-carry adder.
package rca_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

  function automatic bit width_legal(input int width);
    return (width >= SLICE_W) && ((width % SLICE_W) == 0);
  endfunction

  // A single-slice build still needs a 1-bit index so the counter is never zero-width.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_adder_if.sv
// Request/result bundle between two operand producers, the adder and one result consumer.
interface rca_seq_adder_if #(
  parameter int WIDTH = 16
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic             req_cin0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic             req_cin1;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             busy;

  // master: requesters plus the result consumer
  modport master (
    output req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1, res_ready,
    input  req_ready, res_valid, res_id, res_sum, res_cout, busy
  );

  // slave: the adder block
  modport slave (
    input  req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1, res_ready,
    output req_ready, res_valid, res_id, res_sum, res_cout, busy
  );

endinterface

// File: rtl/rca_seq_adder_rca.sv
// 4-bit ripple-carry adder slice shared by every cycle of a wide addition.
module rca
  import rca_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[SLICE_W];

endmodule

// File: rtl/rca_seq_adder.sv
// Wide adder that walks one 4-bit slice per cycle, LSB first, arbitrating two requesters round-robin.
module rca_seq_adder
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rca_seq_adder_if.slave  bus
);

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (!width_legal(WIDTH)) begin : g_bad_width
      $error("rca_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             id_reg, id_next;
  logic             last_reg, last_next;
  logic             res_valid_reg, res_valid_next;
  logic             busy_reg, busy_next;

  // Arbiter: a lone request wins outright; on a tie the requester not served last wins.
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  assign grant_valid = |bus.req_valid;
  assign grant_id    = (&bus.req_valid) ? ~last_reg : bus.req_valid[1];
  assign accept      = (state_reg == IDLE) && grant_valid && rst_n;

  assign bus.req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  assign sel_a   = grant_id ? bus.req_a1   : bus.req_a0;
  assign sel_b   = grant_id ? bus.req_b1   : bus.req_b0;
  assign sel_cin = grant_id ? bus.req_cin1 : bus.req_cin0;

  // Operand slice mux feeding the shared adder.
  logic [SLICE_W-1:0] a_slices [NSLICE];
  logic [SLICE_W-1:0] b_slices [NSLICE];
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slices[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_slices[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign slice_a = a_slices[idx_reg];
  assign slice_b = b_slices[idx_reg];

  rca u_rca (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    sum_next       = sum_reg;
    carry_next     = carry_reg;
    cout_next      = cout_reg;
    idx_next       = idx_reg;
    id_next        = id_reg;
    last_next      = last_reg;
    res_valid_next = res_valid_reg;
    busy_next      = busy_reg;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          a_next     = sel_a;
          b_next     = sel_b;
          carry_next = sel_cin;
          sum_next   = '0;
          idx_next   = '0;
          id_next    = grant_id;
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end

      RUN: begin
        sum_next[idx_reg*SLICE_W +: SLICE_W] = slice_sum;
        carry_next = slice_cout;
        idx_next   = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          cout_next      = slice_cout;
          res_valid_next = 1'b1;
          state_next     = DONE;
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          res_valid_next = 1'b0;
          busy_next      = 1'b0;
          last_next      = id_reg;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // LAST resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      idx_reg       <= '0;
      id_reg        <= 1'b0;
      last_reg      <= 1'b1;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      sum_reg       <= sum_next;
      carry_reg     <= carry_next;
      cout_reg      <= cout_next;
      idx_reg       <= idx_next;
      id_reg        <= id_next;
      last_reg      <= last_next;
      res_valid_reg <= res_valid_next;
      busy_reg      <= busy_next;
    end
  end

  assign bus.res_valid = res_valid_reg;
  assign bus.res_sum   = sum_reg;
  assign bus.res_cout  = cout_reg;
  assign bus.res_id    = id_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Self-checking bench: directed vector table, arbitration/backpressure/reset sequences, random traffic.
module tb_rca_seq_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rca_seq_adder_if #(.WIDTH(W)) bus ();

  rca_seq_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit last_m   = 1'b1;

  typedef struct {
    logic [1:0]   vmask;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         cin0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         cin1;
    logic         exp_id;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One accepted operation, entered and left at a negedge. Model: round-robin grant,
  // result = A + B + CIN of the granted requester as seen at the accept edge.
  task automatic txn(input int bp, input bit keep, output logic got_id,
                     output logic [W-1:0] got_sum, output logic got_cout);
    logic [1:0] vm;
    logic       g;
    logic [W:0] exp;
    int         lat;
    int         bad;
    vm = bus.req_valid;
    g  = (vm == 2'b11) ? ~last_m : vm[1];
    if (g)
      exp = {1'b0, bus.req_a1} + {1'b0, bus.req_b1} + {{W{1'b0}}, bus.req_cin1};
    else
      exp = {1'b0, bus.req_a0} + {1'b0, bus.req_b0} + {{W{1'b0}}, bus.req_cin0};
    bus.res_ready = 1'b0;
    #1;
    check("grant_ready", 32'(bus.req_ready), g ? 32'h2 : 32'h1);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid[g] = 1'b0;
    // Scramble both requesters' operands: the accepted one must be ignored, the waiting one used later.
    bus.req_a0 = W'($urandom); bus.req_b0 = W'($urandom); bus.req_cin0 = 1'($urandom);
    bus.req_a1 = W'($urandom); bus.req_b1 = W'($urandom); bus.req_cin1 = 1'($urandom);
    lat = 0;
    bad = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.req_ready != 2'b00) bad++;
      if (bus.res_valid) break;
    end
    check("res_latency", 32'(lat), 32'd5);
    check("res_sum", 32'(bus.res_sum), 32'(exp[W-1:0]));
    check("res_cout", 32'(bus.res_cout), 32'(exp[W]));
    check("res_id", 32'(bus.res_id), 32'(g));
    check("busy_done", 32'(bus.busy), 32'd1);
    got_id   = bus.res_id;
    got_sum  = bus.res_sum;
    got_cout = bus.res_cout;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) bad++;
      check("hold_result", {14'd0, bus.res_valid, bus.res_id, bus.res_cout, bus.res_sum},
            {14'd0, 1'b1, g, exp[W], exp[W-1:0]});
    end
    check("ready_while_busy", 32'(bad), 32'd0);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    last_m = g;
    @(negedge clk);
    check("idle_after_ack", {30'd0, bus.res_valid, bus.busy}, 32'd0);
  endtask

  logic         t_id;
  logic [W-1:0] t_sum;
  logic         t_cout;
  int           stale;
  logic [1:0]   arb_seq [4];

  initial begin
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b0;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_cin0 = 1'b0;
    bus.req_a1 = '0; bus.req_b1 = '0; bus.req_cin1 = 1'b0;

    vecs[0] = '{2'b01, 16'h1234, 16'h4321, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{2'b01, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'h000F, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0};
    vecs[4] = '{2'b11, 16'h8000, 16'h8000, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{2'b11, 16'h0001, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1};
    arb_seq = '{2'd0, 2'd1, 2'd0, 2'd1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", {26'd0, bus.req_ready, bus.res_valid, bus.res_cout, bus.res_id, bus.busy}, 32'd0);
    check("rst_sum", 32'(bus.res_sum), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      bus.req_a0 = vecs[i].a0; bus.req_b0 = vecs[i].b0; bus.req_cin0 = vecs[i].cin0;
      bus.req_a1 = vecs[i].a1; bus.req_b1 = vecs[i].b1; bus.req_cin1 = vecs[i].cin1;
      bus.req_valid = vecs[i].vmask;
      txn(0, 1'b0, t_id, t_sum, t_cout);
      check("tbl_sum", 32'(t_sum), 32'(vecs[i].exp_sum));
      check("tbl_cout", 32'(t_cout), 32'(vecs[i].exp_cout));
      check("tbl_id", 32'(t_id), 32'(vecs[i].exp_id));
      $display("vec %0d: id=%0d sum=0x%04h cout=%0d", i, t_id, t_sum, t_cout);
    end

    // Arbitration: both requesters held valid, grants must alternate starting with 0
    bus.req_valid = 2'b00;
    bus.req_a0 = 16'h0101; bus.req_b0 = 16'h0202; bus.req_cin0 = 1'b0;
    bus.req_a1 = 16'h7FFF; bus.req_b1 = 16'h0001; bus.req_cin1 = 1'b1;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b1, t_id, t_sum, t_cout);
      check("arb_order", 32'(t_id), 32'(arb_seq[i]));
      $display("arb %0d: id=%0d sum=0x%04h cout=%0d", i, t_id, t_sum, t_cout);
    end

    // Backpressure: result held 3 cycles, then next accept on the edge after returning to IDLE
    txn(3, 1'b1, t_id, t_sum, t_cout);
    $display("backpressure: id=%0d sum=0x%04h cout=%0d", t_id, t_sum, t_cout);
    txn(0, 1'b0, t_id, t_sum, t_cout);
    $display("post-backpressure: id=%0d sum=0x%04h cout=%0d", t_id, t_sum, t_cout);

    // Reset while the third slice is being processed
    bus.req_valid = 2'b10;
    bus.req_a1 = 16'h1111; bus.req_b1 = 16'h2222; bus.req_cin1 = 1'b0;
    #1;
    check("mid_rst_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_rst_pre_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {26'd0, bus.req_ready, bus.res_valid, bus.res_cout, bus.res_id, bus.busy}, 32'd0);
    check("mid_rst_sum", 32'(bus.res_sum), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_m = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) stale++;
    end
    check("no_stale_result", 32'(stale), 32'd0);
    bus.req_a0 = 16'h0F0F; bus.req_b0 = 16'hF0F1; bus.req_cin0 = 1'b0;
    bus.req_a1 = 16'h1234; bus.req_b1 = 16'h1111; bus.req_cin1 = 1'b1;
    bus.req_valid = 2'b11;
    txn(0, 1'b0, t_id, t_sum, t_cout);
    check("post_rst_id", 32'(t_id), 32'd0);
    check("post_rst_sum", {15'd0, t_cout, t_sum}, 32'h10000);
    $display("post-reset: id=%0d sum=0x%04h cout=%0d", t_id, t_sum, t_cout);

    // Random traffic against the arithmetic/round-robin model
    for (int i = 0; i < 25; i++) begin
      bus.req_a0 = W'($urandom); bus.req_b0 = W'($urandom); bus.req_cin0 = 1'($urandom);
      bus.req_a1 = W'($urandom); bus.req_b1 = W'($urandom); bus.req_cin1 = 1'($urandom);
      bus.req_valid = 2'($urandom_range(3, 1));
      txn($urandom_range(2, 0), 1'($urandom), t_id, t_sum, t_cout);
      $display("rand %0d: id=%0d sum=0x%04h cout=%0d", i, t_id, t_sum, t_cout);
    end
    bus.req_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rca_seq_adder.md
# rca_seq_adder

Multi-cycle wide adder that time-multiplexes one 4-bit ripple-carry adder slice between two requesters. Each accepted request adds two WIDTH-bit operands plus a carry-in, one 4-bit slice per cycle, LSB first, chaining the carry through a register. The block sits between operand producers and a single result consumer and owns the only adder slice.

## Interface

**Parameters**
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived slice count; not overridable.

**Ports**
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset; asynchronous assert, active-low.
- REQ_VALID  in  2  per-requester request valid; bit i belongs to requester i.
- REQ_READY  out  2  per-requester accept; one-hot or zero.
- REQ_A0, REQ_B0  in  WIDTH  requester 0 operands.
- REQ_CIN0  in  1  requester 0 carry-in.
- REQ_A1, REQ_B1  in  WIDTH  requester 1 operands.
- REQ_CIN1  in  1  requester 1 carry-in.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  consumer accept.
- RES_ID  out  1  requester index that owns the result.
- RES_SUM  out  WIDTH  sum.
- RES_COUT  out  1  carry out of the MSB slice.
- BUSY  out  1  high in RUN or DONE.

## Operation

- **FSM states:** IDLE, RUN, DONE.
- **IDLE**
  - Grant g is chosen combinationally from REQ_VALID.
  - If only one request is valid, that requester is granted.
  - If both are valid, the requester other than LAST is granted (round-robin).
  - REQ_READY[g] = 1 in IDLE only; a transfer occurs when REQ_VALID[g] & REQ_READY[g].
  - On transfer: latch A, B and CIN of requester g, set carry := CIN, idx := 0, ID := g, clear the SUM register, go to RUN.
- **RUN**
  - The slice adds A[4·idx+3:4·idx] + B[4·idx+3:4·idx] + carry.
  - SUM[4·idx+3:4·idx] := slice SUM; carry := slice COUT; idx := idx+1.
  - When idx == NSLICE-1, go to DONE.
- **DONE**
  - RES_VALID = 1; RES_SUM, RES_COUT (the final carry) and RES_ID are held stable.
  - When RES_READY = 1: go to IDLE and set LAST := ID.
- **Arithmetic:** the result is the full (WIDTH+1)-bit value {RES_COUT, RES_SUM} = A + B + CIN, and it never wraps silently.
- **Request rules**
  - REQ_READY is 0 in RUN and DONE.
  - A requester holding REQ_VALID while the block is busy waits with no side effect.
  - Operand changes after acceptance are ignored.
- **Reset values:** state IDLE, REQ_READY 0 (until IDLE evaluation), RES_VALID 0, RES_SUM 0, RES_COUT 0, RES_ID 0, BUSY 0, LAST 1 (so requester 0 wins the first tie).
- **Reset mid-operation:** the in-flight operation is discarded and no result is produced; the next request after reset release starts cleanly.

## Timing

- Accept at edge T (IDLE, handshake).
- RUN occupies edges T+1 … T+NSLICE.
- RES_VALID is high from the cycle after edge T+NSLICE; that is 5 cycles after accept for WIDTH=16.
- Result held until the RES_READY edge; the block returns to IDLE on that edge.
- The earliest next accept is the following edge, so back-to-back throughput is one op per NSLICE+2 cycles with RES_READY tied high.
- REQ_READY depends combinationally on REQ_VALID and state only; there is no path from RES_READY to REQ_READY.
- All outputs except REQ_READY are registered.

## Structure

- **Package rca_seq_pkg**
  - SLICE_W = 4.
  - State enum {IDLE, RUN, DONE}.
  - Function computing NSLICE.
- **Sub-module:** one instance of the team's 4-bit ripple-carry adder RCA (A, B, CIN → SUM, COUT), fed by muxed operand slices and the carry register.
- **Top module owns:** FSM, arbiter (LAST pointer), operand/SUM/carry registers, idx counter of width $clog2(NSLICE).

## Test plan

1. **Basic add:** req0 A=0x1234, B=0x4321, CIN=0 → RES_SUM=0x5555, RES_COUT=0, RES_ID=0, RES_VALID exactly 5 cycles after accept.
2. **Full carry ripple:** req1 A=0xFFFF, B=0x0001, CIN=0 → RES_SUM=0x0000, RES_COUT=1, RES_ID=1.
3. **Carry-in only:** A=0xFFFF, B=0x0000, CIN=1 → 0x0000, COUT=1; separately A=0x000F, B=0x0000, CIN=1 → 0x0010, COUT=0.
4. **Arbitration:** both REQ_VALID held continuously with distinct operands → grants go 0,1,0,1; REQ_READY is never high during BUSY, and the operand change made by the losing requester while waiting is used at its later grant.
5. **Backpressure:** RES_READY low for 3 cycles in DONE → RES_SUM, RES_COUT and RES_ID stable and no new accept; RES_READY high → IDLE next cycle, accept the following edge.
6. **Reset mid-RUN:** RST_N low at idx=2 → outputs at reset values immediately (asynchronous), no stale RES_VALID; a new request after release gives the correct sum.
